// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with single-cycle operations plus an iterative
// multiply/divide unit that owns the architectural HI/LO registers.
// Multiply is radix-2 shift-add, divide is restoring shift-subtract; both
// run on magnitudes, and the sign is applied in the final (FIN) cycle.
module alu_muldiv #(
  parameter int DATA_SIZE     = 32,
  parameter int ALU_CTRL_SIZE = 5,
  parameter int CNT_SIZE      = 6
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic                     i_flush,
  input  logic [DATA_SIZE-1:0]     i_A,
  input  logic [DATA_SIZE-1:0]     i_B,
  input  logic [ALU_CTRL_SIZE-1:0] i_alu_ctrl,
  output logic [DATA_SIZE-1:0]     o_result,
  output logic                     o_zero,
  output logic                     o_busy,
  output logic                     o_stall,
  output logic                     o_done
);

  localparam logic [ALU_CTRL_SIZE-1:0] OP_SLL   = ALU_CTRL_SIZE'('h00);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_SRL   = ALU_CTRL_SIZE'('h01);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_SRA   = ALU_CTRL_SIZE'('h02);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_ADD   = ALU_CTRL_SIZE'('h03);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_SUB   = ALU_CTRL_SIZE'('h04);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_AND   = ALU_CTRL_SIZE'('h05);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_OR    = ALU_CTRL_SIZE'('h06);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_XOR   = ALU_CTRL_SIZE'('h07);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_NOR   = ALU_CTRL_SIZE'('h08);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_SLT   = ALU_CTRL_SIZE'('h09);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_LUI   = ALU_CTRL_SIZE'('h0A);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_EQ    = ALU_CTRL_SIZE'('h0B);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_NE    = ALU_CTRL_SIZE'('h0C);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_MULT  = ALU_CTRL_SIZE'('h0D);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_DIV   = ALU_CTRL_SIZE'('h0F);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_DIVU  = ALU_CTRL_SIZE'('h10);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_MFHI  = ALU_CTRL_SIZE'('h11);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_MFLO  = ALU_CTRL_SIZE'('h12);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_MTHI  = ALU_CTRL_SIZE'('h13);
  localparam logic [ALU_CTRL_SIZE-1:0] OP_MTLO  = ALU_CTRL_SIZE'('h14);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t state, state_next;

  logic [DATA_SIZE-1:0]   hi, lo;
  logic [DATA_SIZE-1:0]   acc;      // partial product high half / remainder
  logic [DATA_SIZE-1:0]   quo;      // multiplier / dividend shifting into quotient
  logic [DATA_SIZE-1:0]   opnd;     // multiplicand / divisor magnitude
  logic [CNT_SIZE-1:0]    cnt;
  logic                   is_div, neg_lo, neg_hi, div_zero;

  logic                   is_start_op, is_hilo_op, is_signed_op, is_div_op, start;
  logic                   a_neg, b_neg, rem_ge, last_step;
  logic [DATA_SIZE-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [DATA_SIZE:0]     mul_sum, rem_shift;
  logic [2*DATA_SIZE-1:0] prod_fix;

  assign is_start_op  = (i_alu_ctrl >= OP_MULT) && (i_alu_ctrl <= OP_DIVU);
  assign is_hilo_op   = (i_alu_ctrl >= OP_MULT) && (i_alu_ctrl <= OP_MTLO);
  assign is_signed_op = (i_alu_ctrl == OP_MULT) || (i_alu_ctrl == OP_DIV);
  assign is_div_op    = (i_alu_ctrl == OP_DIV)  || (i_alu_ctrl == OP_DIVU);

  // Busy comes straight from the state so stall never loops back into start.
  assign o_busy  = (state != S_IDLE);
  assign o_stall = o_busy & i_valid & is_hilo_op;
  assign start   = (state == S_IDLE) & i_valid & is_start_op & ~i_flush;

  assign a_neg = is_signed_op & i_A[DATA_SIZE-1];
  assign b_neg = is_signed_op & i_B[DATA_SIZE-1];
  assign a_mag = a_neg ? -i_A : i_A;
  assign b_mag = b_neg ? -i_B : i_B;

  // One iteration of each algorithm on the current datapath registers.
  assign mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
  assign rem_shift = {acc, quo[DATA_SIZE-1]};
  assign rem_ge    = (rem_shift >= {1'b0, opnd});
  assign last_step = (cnt == CNT_SIZE'(DATA_SIZE - 1));

  // Sign fixup; a zero divisor forces an all-ones quotient and, because the
  // remainder holds |dividend|, the sign fixup restores the dividend itself.
  assign prod_fix = neg_lo ? -{acc, quo} : {acc, quo};
  assign quo_fix  = div_zero ? '1 : (neg_lo ? -quo : quo);
  assign rem_fix  = neg_hi ? -acc : acc;

  // Single-cycle result mux and HI/LO reads.
  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    o_result = '0;
    case (i_alu_ctrl)
      OP_SLL:  o_result = i_B << i_A[4:0];
      OP_SRL:  o_result = i_B >> i_A[4:0];
      OP_SRA:  o_result = $signed(i_B) >>> i_A[4:0];
      OP_ADD:  o_result = i_A + i_B;
      OP_SUB:  o_result = i_A - i_B;
      OP_AND:  o_result = i_A & i_B;
      OP_OR:   o_result = i_A | i_B;
      OP_XOR:  o_result = i_A ^ i_B;
      OP_NOR:  o_result = ~(i_A | i_B);
      OP_SLT:  o_result = {{(DATA_SIZE-1){1'b0}}, ($signed(i_A) < $signed(i_B))};
      OP_LUI:  o_result = i_B << 16;
      OP_EQ:   o_result = {{(DATA_SIZE-1){1'b0}}, (i_A == i_B)};
      OP_NE:   o_result = {{(DATA_SIZE-1){1'b0}}, (i_A != i_B)};
      OP_MFHI: o_result = hi;
      OP_MFLO: o_result = lo;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

  // State register.
  // NOTE: clocked blocks use non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic and the completion pulse.
  always_comb begin
    state_next = state;
    o_done     = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        if (i_flush)        state_next = S_IDLE;
        else if (last_step) state_next = S_FIN;
      end
      S_FIN: begin
        o_done     = ~i_flush;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture on accept and one iteration per RUN cycle.
  // NOTE: datapath registers are reset as well, so a reset mid-operation leaves no stale operands.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      acc      <= '0;
      quo      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc      <= '0;
            quo      <= a_mag;
            opnd     <= b_mag;
            cnt      <= '0;
            is_div   <= is_div_op;
            neg_lo   <= a_neg ^ b_neg;
            neg_hi   <= a_neg;
            div_zero <= is_div_op & (i_B == '0);
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= rem_ge ? DATA_SIZE'(rem_shift - {1'b0, opnd}) : rem_shift[DATA_SIZE-1:0];
            quo <= {quo[DATA_SIZE-2:0], rem_ge};
          end else begin
            acc <= mul_sum[DATA_SIZE:1];
            quo <= {mul_sum[0], quo[DATA_SIZE-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural HI/LO: written on completion or by an unstalled MTHI/MTLO.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      hi <= '0;
      lo <= '0;
    end else if (o_done) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[2*DATA_SIZE-1:DATA_SIZE];
        lo <= prod_fix[DATA_SIZE-1:0];
      end
    end else if (i_valid && !o_stall) begin
      if (i_alu_ctrl == OP_MTHI) hi <= i_A;
      if (i_alu_ctrl == OP_MTLO) lo <= i_A;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed cases from the block's test plan with literal
// expectations, then randomized traffic, all compared every cycle against a
// behavioural model that tracks HI/LO and unit occupancy as a cycle count.
module tb_alu_muldiv;

  localparam int W = 32;

  localparam logic [4:0] C_SLL  = 5'h00, C_SUB  = 5'h04, C_ADD  = 5'h03,
                         C_SRA  = 5'h02, C_SLT  = 5'h09, C_LUI  = 5'h0A,
                         C_MULT = 5'h0D, C_MULTU = 5'h0E, C_DIV = 5'h0F,
                         C_DIVU = 5'h10, C_MFHI = 5'h11, C_MFLO = 5'h12,
                         C_MTHI = 5'h13, C_MTLO = 5'h14;

  logic         i_clk, i_reset, i_valid, i_flush;
  logic [W-1:0] i_A, i_B;
  logic [4:0]   i_alu_ctrl;
  logic [W-1:0] o_result;
  logic         o_zero, o_busy, o_stall, o_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: HI/LO, pending result, cycles of occupancy left.
  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  alu_muldiv #(.DATA_SIZE(W), .ALU_CTRL_SIZE(5), .CNT_SIZE(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
    .i_A(i_A), .i_B(i_B), .i_alu_ctrl(i_alu_ctrl),
    .o_result(o_result), .o_zero(o_zero), .o_busy(o_busy),
    .o_stall(o_stall), .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic bit is_start(input logic [4:0] c);
    return (c >= 5'h0D) && (c <= 5'h10);
  endfunction

  function automatic bit is_hilo(input logic [4:0] c);
    return (c >= 5'h0D) && (c <= 5'h14);
  endfunction

  // {HI, LO} an operation must leave behind, from plain arithmetic.
  function automatic logic [63:0] muldiv_ref(input logic [4:0] c, input logic [W-1:0] a, b);
    longint       sa, sb;
    logic [63:0]  ua, ub;
    int           ia, ib, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (c)
      C_MULT:  return 64'(sa * sb);
      C_MULTU: return ua * ub;
      C_DIV: begin
        if (b == '0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == '0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] exp_result(input logic [4:0] c, input logic [W-1:0] a, b, hi, lo);
    logic [4:0] sh;
    sh = a[4:0];
    case (c)
      5'h00: return b << sh;
      5'h01: return b >> sh;
      5'h02: return $signed(b) >>> sh;
      5'h03: return a + b;
      5'h04: return a - b;
      5'h05: return a & b;
      5'h06: return a | b;
      5'h07: return a ^ b;
      5'h08: return ~(a | b);
      5'h09: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'h0A: return {b[15:0], 16'h0000};
      5'h0B: return (a == b) ? 32'd1 : 32'd0;
      5'h0C: return (a != b) ? 32'd1 : 32'd0;
      5'h11: return hi;
      5'h12: return lo;
      default: return '0;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge.
  always @(posedge i_clk) begin
    if (!i_reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      if (m_left > 0) begin
        if (i_flush) m_left <= 0;
        else if (m_left == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_left <= 0;
        end else m_left <= m_left - 1;
      end else if (i_valid && is_start(i_alu_ctrl) && !i_flush) begin
        {p_hi, p_lo} <= muldiv_ref(i_alu_ctrl, i_A, i_B);
        m_left       <= W + 1;
      end
      if (m_left == 0 && i_valid && i_alu_ctrl == C_MTHI) m_hi <= i_A;
      if (m_left == 0 && i_valid && i_alu_ctrl == C_MTLO) m_lo <= i_A;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("result", o_result, exp_result(i_alu_ctrl, i_A, i_B, m_hi, m_lo));
      check("zero",   o_zero,   (exp_result(i_alu_ctrl, i_A, i_B, m_hi, m_lo) == '0));
      check("busy",   o_busy,   (m_left > 0));
      check("stall",  o_stall,  (m_left > 0) && i_valid && is_hilo(i_alu_ctrl));
      check("done",   o_done,   (m_left == 1) && !i_flush);
    end
  end

  task automatic apply(input logic v, input logic [4:0] c, input logic [W-1:0] a, b, input logic f);
    @(posedge i_clk);
    #1;
    i_reset    = 1'b1;
    i_valid    = v;
    i_alu_ctrl = c;
    i_A        = a;
    i_B        = b;
    i_flush    = f;
  endtask

  task automatic idle();
    apply(1'b0, C_SLL, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_reset    = 1'b0;
    i_valid    = 1'b0;
    i_flush    = 1'b0;
    i_alu_ctrl = C_SLL;
  endtask

  task automatic read_hilo(input string name, input logic [W-1:0] ehi, elo);
    apply(1'b1, C_MFHI, '0, '0, 1'b0);
    @(negedge i_clk);
    check({name, "_hi"}, o_result, ehi);
    apply(1'b1, C_MFLO, '0, '0, 1'b0);
    @(negedge i_clk);
    check({name, "_lo"}, o_result, elo);
  endtask

  task automatic run_and_read(input string name, input logic [4:0] c, input logic [W-1:0] a, b, ehi, elo);
    apply(1'b1, c, a, b, 1'b0);
    repeat (W + 1) idle();
    read_hilo(name, ehi, elo);
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h80000000;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] rand_code();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)      return 5'($urandom_range(0, 12));
    else if (r < 8) return 5'($urandom_range(13, 20));
    else            return 5'($urandom_range(21, 31));
  endfunction

  initial begin
    int nb, done_at, ns, nd;
    i_reset = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
    i_A = '0; i_B = '0; i_alu_ctrl = C_SLL;
    do_reset();
    do_reset();
    idle();
    chk_en = 1'b1;
    @(negedge i_clk);
    check("rst_busy", o_busy, 1'b0);
    read_hilo("rst_init", 32'h0, 32'h0);

    // Single-cycle regressions.
    apply(1'b1, C_ADD, 32'd5, 32'hFFFFFFFD, 1'b0); @(negedge i_clk);
    check("add_res", o_result, 32'd2); check("add_zero", o_zero, 1'b0);
    apply(1'b1, C_SUB, 32'd7, 32'd7, 1'b0); @(negedge i_clk);
    check("sub_res", o_result, 32'd0); check("sub_zero", o_zero, 1'b1);
    apply(1'b1, C_SRA, 32'd4, 32'h80000000, 1'b0); @(negedge i_clk);
    check("sra_res", o_result, 32'hF8000000);
    apply(1'b1, C_SLT, 32'hFFFFFFFF, 32'd1, 1'b0); @(negedge i_clk);
    check("slt_res", o_result, 32'd1);
    apply(1'b1, C_LUI, 32'd0, 32'h1234, 1'b0); @(negedge i_clk);
    check("lui_res", o_result, 32'h12340000);

    // MULT latency and result.
    apply(1'b1, C_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
    nb = 0; done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      idle();
      @(negedge i_clk);
      if (o_busy) nb++;
      if (o_done && done_at == 0) done_at = k;
    end
    check("mult_busy_cycles", nb, 33);
    check("mult_done_cycle", done_at, 33);
    read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

    run_and_read("multu", C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_and_read("divu", C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_and_read("div_neg", C_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_and_read("div_min", C_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_and_read("div_zero", C_DIV, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
    run_and_read("div_zero_neg", C_DIV, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF);

    // Dependent MFLO stalls until the cycle after o_done.
    apply(1'b1, C_MULT, 32'h12345, 32'h1000, 1'b0);
    ns = 0;
    for (int k = 0; k < 40; k++) begin
      apply(1'b1, C_MFLO, '0, '0, 1'b0);
      @(negedge i_clk);
      if (!o_stall) break;
      ns++;
    end
    check("stall_cycles", ns, 33);
    check("stall_mflo", o_result, 32'h12345000);

    // Single-cycle op while busy is not stalled.
    apply(1'b1, C_MULTU, 32'd3, 32'd4, 1'b0);
    apply(1'b1, C_ADD, 32'd100, 32'd23, 1'b0); @(negedge i_clk);
    check("busy_add_stall", o_stall, 1'b0);
    check("busy_add_res", o_result, 32'd123);
    check("busy_add_busy", o_busy, 1'b1);
    repeat (W + 1) idle();
    read_hilo("multu_small", 32'd0, 32'd12);

    // Flush at RUN cycle 10.
    apply(1'b1, C_MTLO, 32'h55, '0, 1'b0);
    apply(1'b1, C_DIV, 32'd100, 32'd3, 1'b0);
    repeat (9) idle();
    apply(1'b0, C_SLL, '0, '0, 1'b1); @(negedge i_clk);
    check("flush_busy_during", o_busy, 1'b1);
    idle(); @(negedge i_clk);
    check("flush_busy_after", o_busy, 1'b0);
    nd = 0;
    repeat (35) begin
      idle();
      @(negedge i_clk);
      if (o_done) nd++;
    end
    check("flush_no_done", nd, 0);
    apply(1'b1, C_MFLO, '0, '0, 1'b0); @(negedge i_clk);
    check("flush_mflo", o_result, 32'h55);

    // Reset in the middle of a MULT.
    apply(1'b1, C_MULT, 32'd5, 32'd5, 1'b0);
    repeat (10) idle();
    do_reset();
    idle(); @(negedge i_clk);
    check("rst_mid_busy", o_busy, 1'b0);
    read_hilo("rst_mid", 32'h0, 32'h0);
    run_and_read("rst_mult", C_MULT, 32'd2, 32'd3, 32'd0, 32'd6);

    // Randomized traffic, checked every cycle by the model.
    for (int k = 0; k < 1500; k++) begin
      @(posedge i_clk);
      #1;
      i_reset    = ($urandom_range(0, 299) != 0);
      i_valid    = ($urandom_range(0, 4) != 0);
      i_flush    = ($urandom_range(0, 29) == 0);
      i_alu_ctrl = rand_code();
      i_A        = rand_op();
      i_B        = rand_op();
    end
    repeat (W + 3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
